hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline (F, D, E, M, W).
- Generates the stall and flush enables for every inter-stage flop, and the E-stage forwarding selects.
- Holds the whole pipeline during multi-cycle data-memory accesses, using a small FSM with a timeout watchdog.

Parameters:
- RA_W, 4, register-address width (16 architectural registers).
- MAX_WAIT, 15, maximum M-stage memory wait cycles before timeout error.
- CNT_W, 4, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- RA1D, RA2D  in  RA_W  D-stage source registers.
- RA1E, RA2E  in  RA_W  E-stage source registers.
- WA3E, WA3M, WA3W  in  RA_W  destination registers in E/M/W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- MemtoRegE  in  1  E-stage instruction is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction in stage writes PC.
- BranchTakenE  in  1  branch resolved taken in E.
- MemReqM  in  1  M-stage data-memory access active.
- MemReadyM  in  1  data memory completes access this cycle.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = ResultW, 10 = ALUOutM.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  clear stage register to bubble.
- MemErr  out  1  sticky memory-timeout flag.
- MemWaitCnt  out  CNT_W  current wait count (debug).

Behaviour:
- Registered state: fsm (RUN, WAIT, ERR), wait_cnt, MemErr. All other outputs are combinational from inputs and state.
- Reset (sync, takes effect at the clock edge):
  - fsm = RUN, wait_cnt = 0, MemErr = 0.
  - While reset is high: all Stall* = 0, FlushD = FlushE = FlushW = 1, Forward* = 00.
  - Reset mid-WAIT or in ERR returns to RUN on that edge.
- Forwarding (every state):
  - ForwardAE = 10 if RegWriteM and WA3M == RA1E; else 01 if RegWriteW and WA3W == RA1E; else 00.
  - M has priority over W. ForwardBE is identical using RA2E.
  - Register 15 (PC) is never forwarded; it forces 00.
- RUN, hazard terms:
  - ldrstall = MemtoRegE & RegWriteE & (WA3E == RA1D | WA3E == RA2D).
  - PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- RUN, outputs:
  - StallF = ldrstall | PCWrPendingF.
  - StallD = ldrstall.
  - StallE = StallM = 0.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = ldrstall | BranchTakenE.
  - FlushW = 0.
- RUN → WAIT: MemReqM & ~MemReadyM.
  - In that same cycle, freeze overrides the RUN outputs: StallF = StallD = StallE = StallM = 1, FlushD = FlushE = 0, FlushW = 1.
  - wait_cnt ← 1.
- WAIT outputs: same freeze pattern every cycle. Load-use and branch terms are ignored (masked, not lost); they re-evaluate on return to RUN.
- WAIT transitions:
  - MemReadyM = 1 → RUN. That cycle uses the RUN outputs, with FlushW = 0. wait_cnt ← 0.
  - Else if wait_cnt == MAX_WAIT → ERR, MemErr ← 1.
  - Else wait_cnt ← wait_cnt + 1. The counter saturates and never wraps.
- MemReqM & MemReadyM in the same RUN cycle: single-cycle access, no state change.
- ERR:
  - All Stall* = 1, FlushW = 1, FlushD = FlushE = 0.
  - Held until reset; MemErr stays 1.
  - MemReadyM is ignored.
- MemWaitCnt = wait_cnt.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three outputs, each a 32-bit counter, saturating at 0xFFFFFFFF:
  - PerfLdStall: cycles with ldrstall asserted in RUN.
  - PerfMemStall: cycles in WAIT.
  - PerfFlush: cycles with FlushE asserted in RUN.
- All three clear on reset.
- When undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset held 2 cycles → FlushD/E/W = 1, Stall* = 0, MemErr = 0. Release → all 0, fsm RUN.
- RegWriteM = 1, WA3M = 3, RA1E = 3, plus RegWriteW = 1, WA3W = 3 → ForwardAE = 10. Drop RegWriteM → ForwardAE = 01. RA1E = WA3M = 15 → 00.
- MemtoRegE = 1, RegWriteE = 1, WA3E = 5, RA2D = 5 → StallF = StallD = FlushE = 1 for exactly one cycle.
- MemReqM = 1, MemReadyM = 0 for 3 cycles, then 1 → freeze for 3 cycles (MemWaitCnt 1, 2, 3), then RUN outputs with FlushW = 0. Pending BranchTakenE = 1 → FlushD = FlushE = 1 on the release cycle.
- MemReqM = 1, MemReadyM held 0 → after MAX_WAIT + 1 frozen cycles MemErr = 1 and state is ERR. Asserting MemReadyM has no effect; reset clears MemErr.
- BranchTakenE = 1 with PCSrcE = 1 in RUN → FlushD = FlushE = 1, StallF = 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush enables and a memory-wait FSM with timeout.
// Optional HAZARD_PERF_EN adds saturating 32-bit performance counters.
module hazard_ctrl #(
  parameter int unsigned RA_W     = 4,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] MemWaitCnt
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      PerfLdStall,
  output logic [31:0]      PerfMemStall,
  output logic [31:0]      PerfFlush
`endif
);

  localparam logic [RA_W-1:0]  PC_REG  = RA_W'(15);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             err_nxt;
  logic             ldrstall;
  logic             pc_pend;
  logic             freeze;

  // M-stage result wins over W; the PC register always reads from the regfile path.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] ra,
    input logic            rwm,
    input logic [RA_W-1:0] wam,
    input logic            rww,
    input logic [RA_W-1:0] waw
  );
    if (ra == PC_REG)             return 2'b00;
    else if (rwm && (wam == ra))  return 2'b10;
    else if (rww && (waw == ra))  return 2'b01;
    else                          return 2'b00;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      MemErr   <= err_nxt;
    end
  end

  // Next state and stage controls
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    err_nxt   = MemErr;
    freeze    = 1'b0;

    ldrstall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    pc_pend  = PCSrcD | PCSrcE | PCSrcM;

    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    StallF = ldrstall | pc_pend;
    StallD = ldrstall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = pc_pend | PCSrcW | BranchTakenE;
    FlushE = ldrstall | BranchTakenE;
    FlushW = 1'b0;

    case (state)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(1);
          freeze    = 1'b1;
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == CNT_MAX) begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end else if (wait_cnt != '1) begin
            cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      S_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase

    // Hold every stage and bubble writeback while memory is outstanding or dead.
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end

    if (reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end
  end

  assign MemWaitCnt = wait_cnt;

`ifdef HAZARD_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      PerfLdStall  <= '0;
      PerfMemStall <= '0;
      PerfFlush    <= '0;
    end else begin
      if ((state == S_RUN) && ldrstall && (PerfLdStall != '1))
        PerfLdStall <= PerfLdStall + 32'd1;
      if ((state == S_WAIT) && (PerfMemStall != '1))
        PerfMemStall <= PerfMemStall + 32'd1;
      if ((state == S_RUN) && FlushE && (PerfFlush != '1))
        PerfFlush <= PerfFlush + 32'd1;
    end
  end
`endif

endmodule
